// File: rtl/mctrl_pkg.sv
// mctrl_pkg
//   Shared definitions for the second-generation multi-cycle MIPS controller:
//   state encodings, ALU function codes, exception cause codes, opcode/funct
//   constants and the per-state datapath strobe table.
//   No ports (package).
package mctrl_pkg;

  localparam int ALU_W = 4;

  localparam logic [ALU_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SRA = 4'd8;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'd12;

  localparam logic [4:0] ST_IF     = 5'd0;
  localparam logic [4:0] ST_ID     = 5'd1;
  localparam logic [4:0] ST_EX_R   = 5'd2;
  localparam logic [4:0] ST_EX_MEM = 5'd3;
  localparam logic [4:0] ST_EX_I   = 5'd4;
  localparam logic [4:0] ST_LUI_WB = 5'd5;
  localparam logic [4:0] ST_EX_BEQ = 5'd6;
  localparam logic [4:0] ST_EX_BNE = 5'd7;
  localparam logic [4:0] ST_EX_JR  = 5'd8;
  localparam logic [4:0] ST_EX_J   = 5'd9;
  localparam logic [4:0] ST_EX_JAL = 5'd10;
  localparam logic [4:0] ST_MEM_RD = 5'd11;
  localparam logic [4:0] ST_MEM_WR = 5'd12;
  localparam logic [4:0] ST_WB_R   = 5'd13;
  localparam logic [4:0] ST_WB_I   = 5'd14;
  localparam logic [4:0] ST_WB_LW  = 5'd15;
  localparam logic [4:0] ST_EXC    = 5'd16;

  localparam logic [2:0] EXC_IRQ = 3'd0;
  localparam logic [2:0] EXC_ILL = 3'd1;
  localparam logic [2:0] EXC_OVF = 3'd2;
  localparam logic [2:0] EXC_BUS = 3'd3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       iorD;
    logic       cpuMio;
    logic       regWrite;
    logic       aluSrcA;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branch;
    logic       epcWrite;
    logic       causeWrite;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
  } strobe_t;

  // RegDst: 00 rt, 01 rd, 10 $31.  MemtoReg: 00 ALUOut, 01 MDR, 10 upper
  // immediate, 11 PC.  jr relies on rt being $0 so that ALU computes rs+0.
  function automatic strobe_t stateStrobes(input logic [4:0] st);
    strobe_t s;
    s = '0;
    case (st)
      ST_IF: begin
        s.memRead = 1'b1; s.irWrite = 1'b1; s.cpuMio = 1'b1;
        s.pcWrite = 1'b1; s.aluSrcB = 2'b01;
      end
      ST_ID:     s.aluSrcB = 2'b11;
      ST_EX_R:   s.aluSrcA = 1'b1;
      ST_EX_MEM: begin s.aluSrcA = 1'b1; s.aluSrcB = 2'b10; end
      ST_EX_I:   begin s.aluSrcA = 1'b1; s.aluSrcB = 2'b10; end
      ST_LUI_WB: begin s.regWrite = 1'b1; s.memtoReg = 2'b10; end
      ST_EX_BEQ: begin
        s.aluSrcA = 1'b1; s.pcWriteCond = 1'b1; s.branch = 1'b1; s.pcSource = 2'b01;
      end
      ST_EX_BNE: begin s.aluSrcA = 1'b1; s.pcWriteCond = 1'b1; s.pcSource = 2'b01; end
      ST_EX_JR:  begin s.aluSrcA = 1'b1; s.pcWrite = 1'b1; end
      ST_EX_J:   begin s.pcWrite = 1'b1; s.pcSource = 2'b10; end
      ST_EX_JAL: begin
        s.pcWrite = 1'b1; s.pcSource = 2'b10; s.regWrite = 1'b1;
        s.regDst = 2'b10; s.memtoReg = 2'b11;
      end
      ST_MEM_RD: begin s.memRead = 1'b1; s.iorD = 1'b1; s.cpuMio = 1'b1; end
      ST_MEM_WR: begin s.memWrite = 1'b1; s.iorD = 1'b1; s.cpuMio = 1'b1; end
      ST_WB_R:   begin s.regWrite = 1'b1; s.regDst = 2'b01; end
      ST_WB_I:   s.regWrite = 1'b1;
      ST_WB_LW:  begin s.regWrite = 1'b1; s.memtoReg = 2'b01; end
      ST_EXC: begin
        s.epcWrite = 1'b1; s.causeWrite = 1'b1; s.pcWrite = 1'b1; s.pcSource = 2'b11;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mctrl_alu_dec.sv
// mctrl_alu_dec
//   Combinational ALU function decode for the multi-cycle controller.
//   Ports:
//     state_i   current controller state
//     opcode_i  Inst[31:26]
//     funct_i   Inst[5:0]
//     aluOp_o   ALU function code
module mctrl_alu_dec
  import mctrl_pkg::*;
(
  input  logic [4:0]       state_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  output logic [ALU_W-1:0] aluOp_o
);

  always_comb begin
    aluOp_o = ALU_ADD;
    case (state_i)
      ST_EX_R: begin
        case (funct_i)
          FN_ADD:  aluOp_o = ALU_ADD;
          FN_SUB:  aluOp_o = ALU_SUB;
          FN_AND:  aluOp_o = ALU_AND;
          FN_OR:   aluOp_o = ALU_OR;
          FN_XOR:  aluOp_o = ALU_XOR;
          FN_NOR:  aluOp_o = ALU_NOR;
          FN_SLT:  aluOp_o = ALU_SLT;
          FN_SLL:  aluOp_o = ALU_SLL;
          FN_SRL:  aluOp_o = ALU_SRL;
          FN_SRA:  aluOp_o = ALU_SRA;
          default: aluOp_o = ALU_ADD;
        endcase
      end
      ST_EX_I: begin
        case (opcode_i)
          OP_ANDI: aluOp_o = ALU_AND;
          OP_ORI:  aluOp_o = ALU_OR;
          OP_XORI: aluOp_o = ALU_XOR;
          OP_SLTI: aluOp_o = ALU_SLT;
          default: aluOp_o = ALU_ADD;
        endcase
      end
      // Branch compare is a subtract; the datapath looks at zero.
      ST_EX_BEQ, ST_EX_BNE: aluOp_o = ALU_SUB;
      default: aluOp_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mctrl_gen2.sv
// mctrl_gen2
//   Multi-cycle MIPS control FSM (second generation) with bounded memory wait,
//   precise exceptions and parameterised shift decode.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     Inst_in             instruction register contents
//     zero, overflow      ALU flags
//     MIO_ready           memory/IO handshake
//     irq                 level interrupt request, honoured only in IF
//     state_out           current state code
//     memory/bus strobes  MemRead, MemWrite, IRWrite, IorD, CPU_MIO
//     datapath strobes    RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch
//     mux selects         RegDst, MemtoReg, ALUSrcB, PCSource
//     ALU_operation       ALU function code
//     EPCWrite, CauseWrite, exc_code   exception interface
module mctrl_gen2
  import mctrl_pkg::*;
#(
  parameter int MEM_TMO  = 16,
  parameter int OVF_TRAP = 1,
  parameter int SHIFT_EN = 1,
  parameter int ALUOP_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Inst_in,
  input  logic               zero,
  input  logic               overflow,
  input  logic               MIO_ready,
  input  logic               irq,
  output logic [4:0]         state_out,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               CPU_MIO,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALU_operation,
  output logic               EPCWrite,
  output logic               CauseWrite,
  output logic [2:0]         exc_code
);

  localparam int CNT_W = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((MEM_TMO > 0) ? MEM_TMO - 1 : 0);

  logic [4:0]       state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [2:0]       excCode_q, excCode_d;
  logic [5:0]       opcode, funct;
  logic             isShift, isAddSub, ovfTrap, memTimeout;
  logic [ALU_W-1:0] aluOp;
  strobe_t          strobes;
  logic             unusedInputs;

  assign opcode = Inst_in[31:26];
  assign funct  = Inst_in[5:0];
  // The branch outcome is resolved by the datapath from PCWriteCond/Branch.
  assign unusedInputs = ^{Inst_in[25:6], zero};

  assign isShift    = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  assign isAddSub   = ((state_q == ST_EX_R) && ((funct == FN_ADD) || (funct == FN_SUB))) ||
                      ((state_q == ST_EX_I) && (opcode == OP_ADDI));
  assign ovfTrap    = (OVF_TRAP != 0) && isAddSub && overflow;
  assign memTimeout = (MEM_TMO > 0) && (waitCnt_q == TMO_LAST);

  // The wait counter only survives a stalled memory cycle; every other path
  // leaves it at zero, which covers clearing on entry to IF/MEM_RD/MEM_WR.
  always_comb begin
    state_d   = state_q;
    excCode_d = excCode_q;
    waitCnt_d = '0;
    case (state_q)
      ST_IF: begin
        if (irq) begin
          state_d = ST_EXC; excCode_d = EXC_IRQ;
        end else if (MIO_ready) begin
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR) state_d = ST_EX_JR;
            else if ((SHIFT_EN == 0) && isShift) begin
              state_d = ST_EXC; excCode_d = EXC_ILL;
            end else state_d = ST_EX_R;
          end
          OP_LW, OP_SW: state_d = ST_EX_MEM;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = ST_EX_I;
          OP_LUI: state_d = ST_LUI_WB;
          OP_J:   state_d = ST_EX_J;
          OP_JAL: state_d = ST_EX_JAL;
          OP_BEQ: state_d = ST_EX_BEQ;
          OP_BNE: state_d = ST_EX_BNE;
          default: begin state_d = ST_EXC; excCode_d = EXC_ILL; end
        endcase
      end
      ST_EX_R, ST_EX_I: begin
        if (ovfTrap) begin
          state_d = ST_EXC; excCode_d = EXC_OVF;
        end else begin
          state_d = (state_q == ST_EX_R) ? ST_WB_R : ST_WB_I;
        end
      end
      ST_EX_MEM: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      // A ready in the timeout cycle still completes the access.
      ST_MEM_RD, ST_MEM_WR: begin
        if (MIO_ready) begin
          state_d = (state_q == ST_MEM_RD) ? ST_WB_LW : ST_IF;
        end else if (memTimeout) begin
          state_d = ST_EXC; excCode_d = EXC_BUS;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IF;
      waitCnt_q <= '0;
      excCode_q <= EXC_IRQ;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      excCode_q <= excCode_d;
    end
  end

  mctrl_alu_dec u_alu_dec (
    .state_i (state_q),
    .opcode_i(opcode),
    .funct_i (funct),
    .aluOp_o (aluOp)
  );

  assign strobes       = stateStrobes(state_q);
  assign state_out     = state_q;
  assign MemRead       = strobes.memRead;
  assign MemWrite      = strobes.memWrite;
  assign IRWrite       = strobes.irWrite;
  assign IorD          = strobes.iorD;
  assign CPU_MIO       = strobes.cpuMio;
  assign RegWrite      = strobes.regWrite;
  assign ALUSrcA       = strobes.aluSrcA;
  assign PCWrite       = strobes.pcWrite;
  assign PCWriteCond   = strobes.pcWriteCond;
  assign Branch        = strobes.branch;
  assign RegDst        = strobes.regDst;
  assign MemtoReg      = strobes.memtoReg;
  assign ALUSrcB       = strobes.aluSrcB;
  assign PCSource      = strobes.pcSource;
  assign EPCWrite      = strobes.epcWrite;
  assign CauseWrite    = strobes.causeWrite;
  assign ALU_operation = ALUOP_W'(aluOp);
  assign exc_code      = excCode_q;

endmodule

// File: tb/tb_mctrl_gen2.sv
// tb_mctrl_gen2
//   Self-checking bench for mctrl_gen2: directed instruction sequences followed
//   by randomized traffic, all compared each cycle against a behavioural model.
module tb_mctrl_gen2;
  import mctrl_pkg::*;

  localparam int TMO = 6;

  logic        clk, reset, zero, overflow, MIO_ready, irq;
  logic [31:0] Inst_in;
  logic [4:0]  state_out;
  logic        MemRead, MemWrite, IRWrite, IorD, CPU_MIO, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch, EPCWrite, CauseWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [3:0]  ALU_operation;
  logic [2:0]  exc_code;

  mctrl_gen2 #(.MEM_TMO(TMO), .OVF_TRAP(1), .SHIFT_EN(1), .ALUOP_W(4)) dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .irq(irq), .state_out(state_out),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .IorD(IorD),
    .CPU_MIO(CPU_MIO), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_operation(ALU_operation),
    .EPCWrite(EPCWrite), .CauseWrite(CauseWrite), .exc_code(exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: which step of the instruction we are in, how many
  // consecutive cycles memory has stalled, and the last exception cause.
  logic [4:0] mState;
  int         mStall;
  logic [2:0] mExc;

  logic [5:0] rFuncts [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                               6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011,
                               6'b001000, 6'b111000};
  logic [5:0] iOps [14] = '{6'b100011, 6'b101011, 6'b001000, 6'b001100, 6'b001101,
                            6'b001110, 6'b001010, 6'b001111, 6'b000010, 6'b000011,
                            6'b000100, 6'b000101, 6'b111111, 6'b010000};

  function automatic logic [31:0] mkR(input logic [5:0] f);
    return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, f};
  endfunction

  function automatic logic [31:0] mkI(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h0040};
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 1) return {6'b000000, r[25:6], rFuncts[$urandom_range(0, 11)]};
    return {iOps[$urandom_range(0, 13)], r[25:0]};
  endfunction

  // Packed as {MemRead, MemWrite, IRWrite, IorD, CPU_MIO, RegWrite, ALUSrcA,
  // PCWrite, PCWriteCond, Branch, EPCWrite, CauseWrite, RegDst, MemtoReg,
  // ALUSrcB, PCSource}.
  function automatic logic [19:0] expStrobes(input logic [4:0] s);
    logic mr, mw, ir, iord, mio, rw, sa, pcw, pcc, br, epc, cw;
    logic [1:0] rd, m2r, sb, ps;
    {mr, mw, ir, iord, mio, rw, sa, pcw, pcc, br, epc, cw} = '0;
    {rd, m2r, sb, ps} = '0;
    case (s)
      ST_IF:     begin mr = 1; ir = 1; mio = 1; pcw = 1; sb = 2'b01; end
      ST_ID:     sb = 2'b11;
      ST_EX_R:   sa = 1;
      ST_EX_MEM: begin sa = 1; sb = 2'b10; end
      ST_EX_I:   begin sa = 1; sb = 2'b10; end
      ST_LUI_WB: begin rw = 1; m2r = 2'b10; end
      ST_EX_BEQ: begin sa = 1; pcc = 1; br = 1; ps = 2'b01; end
      ST_EX_BNE: begin sa = 1; pcc = 1; ps = 2'b01; end
      ST_EX_JR:  begin sa = 1; pcw = 1; end
      ST_EX_J:   begin pcw = 1; ps = 2'b10; end
      ST_EX_JAL: begin pcw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b11; end
      ST_MEM_RD: begin mr = 1; iord = 1; mio = 1; end
      ST_MEM_WR: begin mw = 1; iord = 1; mio = 1; end
      ST_WB_R:   begin rw = 1; rd = 2'b01; end
      ST_WB_I:   rw = 1;
      ST_WB_LW:  begin rw = 1; m2r = 2'b01; end
      ST_EXC:    begin epc = 1; cw = 1; pcw = 1; ps = 2'b11; end
      default:   ;
    endcase
    return {mr, mw, ir, iord, mio, rw, sa, pcw, pcc, br, epc, cw, rd, m2r, sb, ps};
  endfunction

  function automatic logic [3:0] expAlu(input logic [4:0] s, input logic [31:0] inst);
    if (s == ST_EX_BEQ || s == ST_EX_BNE) return ALU_SUB;
    if (s == ST_EX_R) begin
      case (inst[5:0])
        6'b100010: return ALU_SUB;
        6'b100100: return ALU_AND;
        6'b100101: return ALU_OR;
        6'b100110: return ALU_XOR;
        6'b100111: return ALU_NOR;
        6'b101010: return ALU_SLT;
        6'b000000: return ALU_SLL;
        6'b000010: return ALU_SRL;
        6'b000011: return ALU_SRA;
        default:   return ALU_ADD;
      endcase
    end
    if (s == ST_EX_I) begin
      case (inst[31:26])
        6'b001100: return ALU_AND;
        6'b001101: return ALU_OR;
        6'b001110: return ALU_XOR;
        6'b001010: return ALU_SLT;
        default:   return ALU_ADD;
      endcase
    end
    return ALU_ADD;
  endfunction

  task automatic raise(input logic [2:0] code);
    mState = ST_EXC;
    mExc   = code;
  endtask

  // Advances the model by one clock according to the controller's rules.
  task automatic modelStep(input logic rst, input logic [31:0] inst, input logic rdy,
                           input logic irqIn, input logic ovf);
    logic [5:0] op, fn;
    logic stalled;
    op = inst[31:26];
    fn = inst[5:0];
    stalled = 1'b0;
    if (rst) begin
      mState = ST_IF; mStall = 0; mExc = 3'd0;
      return;
    end
    case (mState)
      ST_IF: if (irqIn) raise(3'd0); else if (rdy) mState = ST_ID;
      ST_ID: begin
        if (op == 6'b000000) mState = (fn == 6'b001000) ? ST_EX_JR : ST_EX_R;
        else if (op == 6'b100011 || op == 6'b101011) mState = ST_EX_MEM;
        else if (op inside {6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010})
          mState = ST_EX_I;
        else if (op == 6'b001111) mState = ST_LUI_WB;
        else if (op == 6'b000010) mState = ST_EX_J;
        else if (op == 6'b000011) mState = ST_EX_JAL;
        else if (op == 6'b000100) mState = ST_EX_BEQ;
        else if (op == 6'b000101) mState = ST_EX_BNE;
        else raise(3'd1);
      end
      ST_EX_R: if (ovf && (fn == 6'b100000 || fn == 6'b100010)) raise(3'd2);
               else mState = ST_WB_R;
      ST_EX_I: if (ovf && op == 6'b001000) raise(3'd2); else mState = ST_WB_I;
      ST_EX_MEM: mState = (op == 6'b101011) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD, ST_MEM_WR: begin
        if (rdy) mState = (mState == ST_MEM_RD) ? ST_WB_LW : ST_IF;
        else if (mStall + 1 == TMO) raise(3'd3);
        else stalled = 1'b1;
      end
      default: mState = ST_IF;
    endcase
    mStall = stalled ? mStall + 1 : 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check the current state's outputs, then advance.
  task automatic applyStimulus(input logic rst, input logic [31:0] inst, input logic rdy,
                               input logic irqIn, input logic ovf, input logic zr);
    reset = rst; Inst_in = inst; MIO_ready = rdy; irq = irqIn; overflow = ovf; zero = zr;
    #1;
    checkOutput("state", {27'd0, state_out}, {27'd0, mState});
    checkOutput("strobes", {12'd0, MemRead, MemWrite, IRWrite, IorD, CPU_MIO, RegWrite,
                ALUSrcA, PCWrite, PCWriteCond, Branch, EPCWrite, CauseWrite, RegDst,
                MemtoReg, ALUSrcB, PCSource}, {12'd0, expStrobes(mState)});
    checkOutput("alu_op", {28'd0, ALU_operation}, {28'd0, expAlu(mState, inst)});
    checkOutput("exc_code", {29'd0, exc_code}, {29'd0, mExc});
    modelStep(rst, inst, rdy, irqIn, ovf);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] curInst;
  int unsigned readyPct;

  initial begin
    reset = 1'b1; Inst_in = '0; MIO_ready = 1'b0; irq = 1'b0; overflow = 1'b0; zero = 1'b0;
    mState = ST_IF; mStall = 0; mExc = 3'd0;
    @(posedge clk);
    #1;
    $display("[TB] reset released");

    // add: IF -> ID -> EX_R -> WB_R -> IF
    for (int i = 0; i < 4; i++) applyStimulus(0, mkR(6'b100000), 1, 0, 0, 0);
    checkOutput("t1_back_in_if", {27'd0, state_out}, {27'd0, ST_IF});

    // lw with five stalled cycles in MEM_RD
    for (int i = 0; i < 3; i++) applyStimulus(0, mkI(6'b100011), 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, mkI(6'b100011), 0, 0, 0, 0);
    checkOutput("t2_still_mem_rd", {27'd0, state_out}, {27'd0, ST_MEM_RD});
    applyStimulus(0, mkI(6'b100011), 1, 0, 0, 0);
    checkOutput("t2_wb_lw", {27'd0, state_out}, {27'd0, ST_WB_LW});
    checkOutput("t2_memtoreg", {30'd0, MemtoReg}, 32'd1);
    applyStimulus(0, mkI(6'b100011), 1, 0, 0, 0);

    // sw with MIO_ready held low until the timeout fires
    for (int i = 0; i < 3; i++) applyStimulus(0, mkI(6'b101011), 1, 0, 0, 0);
    for (int i = 0; i < TMO; i++) applyStimulus(0, mkI(6'b101011), 0, 0, 0, 0);
    checkOutput("t3_exc_state", {27'd0, state_out}, {27'd0, ST_EXC});
    checkOutput("t3_exc_code", {29'd0, exc_code}, 32'd3);
    checkOutput("t3_epc_write", {31'd0, EPCWrite}, 32'd1);
    applyStimulus(0, mkI(6'b101011), 0, 0, 0, 0);
    checkOutput("t3_epc_one_cycle", {31'd0, EPCWrite}, 32'd0);

    // ready arriving in the last allowed cycle completes the store
    for (int i = 0; i < 3; i++) applyStimulus(0, mkI(6'b101011), 1, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) applyStimulus(0, mkI(6'b101011), 0, 0, 0, 0);
    applyStimulus(0, mkI(6'b101011), 1, 0, 0, 0);
    checkOutput("edge_ready_wins", {27'd0, state_out}, {27'd0, ST_IF});

    // illegal opcode, then add overflow
    for (int i = 0; i < 2; i++) applyStimulus(0, mkI(6'b111111), 1, 0, 0, 0);
    checkOutput("t4_illegal_code", {29'd0, exc_code}, 32'd1);
    applyStimulus(0, mkI(6'b111111), 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, mkR(6'b100000), 1, 0, 1, 0);
    checkOutput("t4_ovf_code", {29'd0, exc_code}, 32'd2);
    checkOutput("t4_no_regwrite", {31'd0, RegWrite}, 32'd0);
    applyStimulus(0, mkR(6'b100000), 1, 0, 0, 0);

    // irq in IF, then irq held during an instruction's later steps
    applyStimulus(0, mkR(6'b100101), 1, 1, 0, 0);
    checkOutput("t5_irq_code", {29'd0, exc_code}, 32'd0);
    applyStimulus(0, mkR(6'b100101), 1, 0, 0, 0);
    applyStimulus(0, mkR(6'b100101), 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, mkR(6'b100101), 1, 1, 0, 0);
    applyStimulus(0, mkR(6'b100101), 1, 1, 0, 0);
    checkOutput("t5_irq_at_if", {27'd0, state_out}, {27'd0, ST_EXC});
    applyStimulus(0, mkR(6'b100101), 1, 0, 0, 0);

    // reset in MEM_WR, then beq with zero=1
    for (int i = 0; i < 3; i++) applyStimulus(0, mkI(6'b101011), 1, 0, 0, 0);
    applyStimulus(0, mkI(6'b101011), 0, 0, 0, 0);
    applyStimulus(1, mkI(6'b101011), 0, 0, 0, 0);
    checkOutput("t6_reset_if", {27'd0, state_out}, {27'd0, ST_IF});
    checkOutput("t6_memwrite", {31'd0, MemWrite}, 32'd0);
    for (int i = 0; i < 2; i++) applyStimulus(0, mkI(6'b000100), 1, 0, 0, 1);
    checkOutput("t6_pcwritecond", {31'd0, PCWriteCond}, 32'd1);
    checkOutput("t6_branch", {31'd0, Branch}, 32'd1);
    applyStimulus(0, mkI(6'b000100), 1, 0, 0, 1);

    $display("[TB] directed sequences done, starting random traffic");
    readyPct = 90;
    curInst  = randInst();
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        case ($urandom_range(0, 3))
          0: readyPct = 95;
          1: readyPct = 50;
          2: readyPct = 15;
          default: readyPct = 0;
        endcase
      end
      if (mState == ST_IF) curInst = randInst();
      applyStimulus(($urandom_range(0, 199) == 0), curInst,
                    ($urandom_range(0, 99) < readyPct), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
